// File: rtl/microcode_seq.sv
// microcode_seq: byte-loadable control store driving a stallable micro-op sequencer with registered control-word output
module microcode_seq #(
    parameter int OPCODE_BITS = 6,
    parameter int UOP_BITS = 5,
    parameter int WORD_WIDTH = 32,
    parameter int RESET_BIT = 14,
    localparam int LANE_BITS = $clog2(WORD_WIDTH / 8)
) (
    input  logic                                     CLK,
    input  logic                                     N_RST,
    input  logic                                     N_BOOTED,
    input  logic                                     BOOTSTRAP_N_WE,
    input  logic [OPCODE_BITS+UOP_BITS+LANE_BITS-1:0] BOOTSTRAP_ADDR,
    input  logic [7:0]                               BOOTSTRAP_DATA,
    input  logic                                     OPCODE_LOAD,
    input  logic [OPCODE_BITS-1:0]                   OPCODE_IN,
    input  logic                                     STALL,
    output logic [WORD_WIDTH-1:0]                    OUT,
    output logic [OPCODE_BITS-1:0]                   OPCODE,
    output logic [UOP_BITS-1:0]                      UOP_COUNT,
    output logic                                     UOP_WRAP
);
    localparam int AW = OPCODE_BITS + UOP_BITS;
    localparam int LW = LANE_BITS > 0 ? LANE_BITS : 1;
    localparam int LANES = WORD_WIDTH / 8;

    typedef enum logic [1:0] {BOOT, START, RUN} state_t;

    state_t                 state, nxt_state;
    logic [OPCODE_BITS-1:0] nxt_op;
    logic [UOP_BITS-1:0]    nxt_uop;
    logic                   nxt_wrap;
    logic                   we;
    logic [LW-1:0]          lane;
    logic [AW-1:0]          waddr, raddr;
    logic [WORD_WIDTH-1:0]  rd_word;

    assign we = state == BOOT && !BOOTSTRAP_N_WE;
    assign waddr = BOOTSTRAP_ADDR[AW+LANE_BITS-1 -: AW];
    assign raddr = {nxt_op, nxt_uop};

    generate
        if (LANE_BITS == 0) begin : g_one
            assign lane = '0;
        end else begin : g_multi
            assign lane = BOOTSTRAP_ADDR[LW-1:0];
        end
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic [7:0] mem [0:(1<<AW)-1];
            always_ff @(posedge CLK)
                if (we && lane == LW'(l)) mem[waddr] <= BOOTSTRAP_DATA;
            assign rd_word[8*l +: 8] = mem[raddr];
        end
    endgenerate

    always_comb begin
        nxt_state = state;
        nxt_op = OPCODE;
        nxt_uop = UOP_COUNT;
        nxt_wrap = UOP_WRAP;
        if (state == BOOT) begin
            nxt_op = '0;
            nxt_uop = '0;
            nxt_state = N_BOOTED ? BOOT : START;
        end else if (N_BOOTED) begin
            nxt_state = BOOT;
            nxt_op = '0;
            nxt_uop = '0;
        end else begin
            nxt_state = RUN;
            if (!STALL) begin
                nxt_uop = OUT[RESET_BIT] ? '0 : UOP_COUNT + 1'b1;
                nxt_wrap = UOP_WRAP | (!OUT[RESET_BIT] && &UOP_COUNT);
                nxt_op = OPCODE_LOAD ? OPCODE_IN : OPCODE;
            end
        end
    end

    // The store is read at the next-state address so OUT tracks {OPCODE, UOP_COUNT} with no lag
    always_ff @(posedge CLK or negedge N_RST)
        if (!N_RST) begin
            state <= BOOT;
            OUT <= '0;
            OPCODE <= '0;
            UOP_COUNT <= '0;
            UOP_WRAP <= 1'b0;
        end else begin
            state <= nxt_state;
            OUT <= nxt_state == BOOT ? '0 : rd_word;
            OPCODE <= nxt_op;
            UOP_COUNT <= nxt_uop;
            UOP_WRAP <= nxt_wrap;
        end
endmodule

// File: doc/microcode_seq.md
Name: microcode_seq

Overview:
- Parametrised microcode sequencer: writable control store, opcode register, micro-op counter and registered control-word output in one block.
- Replaces the fixed microcode lookup. Control store is byte-loaded by the bootstrap path, then sequenced autonomously. Control logic consumes OUT directly.
- Adds behaviour the fixed lookup lacks: stall, reset-field feedback, wrap detection and external opcode load.

Parameters:
- OPCODE_BITS, 6, opcode register width.
- UOP_BITS, 5, micro-op counter width; 2^UOP_BITS words per opcode.
- WORD_WIDTH, 32, control word width; must be a multiple of 8.
- RESET_BIT, 14, index in control word of the micro-op-counter-reset flag; must be < WORD_WIDTH.
- LANE_BITS (localparam), $clog2(WORD_WIDTH/8), byte-lane select bits; 0 when WORD_WIDTH=8.

Ports:
- CLK  in  1  clock, all state on rising edge.
- N_RST  in  1  async active-low reset.
- N_BOOTED  in  1  high = bootstrap mode (store writable, sequencer halted).
- BOOTSTRAP_N_WE  in  1  active-low byte write strobe, sampled on CLK.
- BOOTSTRAP_ADDR  in  OPCODE_BITS+UOP_BITS+LANE_BITS  {opcode, uop, lane}. Lane 0 = bits [7:0].
- BOOTSTRAP_DATA  in  8  byte to write.
- OPCODE_LOAD  in  1  load OPCODE_IN into opcode register.
- OPCODE_IN  in  OPCODE_BITS  next opcode (from decoder).
- STALL  in  1  hold counter, opcode and OUT.
- OUT  out  WORD_WIDTH  current control word.
- OPCODE  out  OPCODE_BITS  current opcode.
- UOP_COUNT  out  UOP_BITS  current micro-op index.
- UOP_WRAP  out  1  sticky: counter wrapped without a reset flag.

Behaviour:
- Reset (N_RST low, async):
  - OUT, OPCODE, UOP_COUNT and UOP_WRAP clear to 0.
  - Control store contents are not affected.
  - State machine goes to BOOT.
- States: BOOT, START, RUN.
- BOOT:
  - OUT held at 0; counter and opcode held at 0.
  - Each rising edge with BOOTSTRAP_N_WE low writes BOOTSTRAP_DATA into the selected byte lane of word {opcode, uop}. Other lanes are unchanged.
  - N_BOOTED low moves the machine to START on the next edge.
  - If N_BOOTED is low when reset deasserts, the first edge goes BOOT->START.
- START (one cycle): reads word {0, 0} into OUT; moves to RUN. OPCODE=0, UOP_COUNT=0 are visible in the same cycle OUT shows word {0,0}.
- RUN: OUT always equals store[{OPCODE, UOP_COUNT}]. Synchronous read uses next-state values as the address, so there is no extra latency. Next-state priority, highest first:
  1. STALL=1: hold everything; OPCODE_LOAD is ignored.
  2. OUT[RESET_BIT]=1: UOP_COUNT<=0. If OPCODE_LOAD=1 in the same cycle, OPCODE<=OPCODE_IN, otherwise OPCODE is held.
  3. Otherwise: UOP_COUNT<=UOP_COUNT+1, modulo 2^UOP_BITS. OPCODE_LOAD=1 loads OPCODE_IN, and the counter still increments.
  4. Increment from all-ones to 0 without RESET_BIT sets UOP_WRAP. UOP_WRAP clears only on reset.
- N_BOOTED rising while in RUN or START: returns to BOOT next edge; OUT<=0, OPCODE<=0, UOP_COUNT<=0; UOP_WRAP is kept.
- Bootstrap writes while not in BOOT are ignored.
- Store implemented as WORD_WIDTH/8 byte-wide RAMs of depth 2^(OPCODE_BITS+UOP_BITS).

Test Plan:
- Boot write: load word {op0,uop0}=0x00004001 byte-wise (lanes 0..3), drop N_BOOTED -> START cycle OUT=0x00004001, UOP_COUNT=0; next cycle UOP_COUNT=0 again (RESET_BIT=14 set), OUT=0x00004001.
- Sequencing: words {1,0..3}=0x10,0x11,0x12,0x4013; OPCODE_LOAD with OPCODE_IN=1 on a reset cycle -> OUT sequence 0x10,0x11,0x12,0x4013,0x10 with UOP_COUNT 0,1,2,3,0.
- Stall: assert STALL 3 cycles at UOP_COUNT=2 -> OUT=0x12 held for 3 cycles, then 0x4013; OPCODE_LOAD during stall ignored.
- Wrap: opcode 2 all words 0 -> after 32 cycles UOP_COUNT returns to 0 and UOP_WRAP=1, sticky until N_RST.
- Partial byte write: in BOOT, rewrite lane 2 of {1,1} with 0xAB -> word reads 0x00AB0011 after boot; writes issued during RUN leave store unchanged.
- Reset mid-run: drop N_RST at UOP_COUNT=3 -> OUT/OPCODE/UOP_COUNT/UOP_WRAP=0 immediately; store preserved (reboot with N_BOOTED low replays 0x00004001).
